mining_job_sequencer: RTL and testbench

//  Sequences one mining job over the header block RAM and the external hash core.

---
 rtl/mining_pkg.sv | 26 ++
 rtl/mining_nonce_iter.sv | 39 +++
 rtl/mining_job_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mining_job_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// mining_pkg: shared definitions for the mining job sequencer.
//   state_t        : encoded sequencer state (also exported on the debug port)
//   HDR_WORDS_DEF  : default header length in words (80-byte header)
//   NONCE_WORD_DEF : default header word index that carries the nonce
//   NONCE_W        : nonce width
//   is_busy()      : true for states that belong to an active job
package mining_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_RUN   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int HDR_WORDS_DEF  = 20;
  localparam int NONCE_WORD_DEF = 19;
  localparam int NONCE_W        = 32;

  function automatic logic is_busy(input state_t s);
    return (s == ST_LOAD) || (s == ST_FEED) || (s == ST_RUN) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/mining_nonce_iter.sv
// mining_nonce_iter: nonce register for one job.
//   clk, reset   : clock, synchronous active-high reset (nonce -> 0)
//   load         : capture nonce_first / nonce_last (accepted job start)
//   inc          : advance nonce by one, wrapping modulo 2**NONCE_W
//   nonce_first  : first nonce of the range
//   nonce_last   : last nonce of the range (inclusive)
//   nonce        : current nonce
//   is_last      : current nonce equals the captured last nonce
module mining_nonce_iter
  import mining_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  output logic [NONCE_W-1:0] nonce,
  output logic               is_last
);

  logic [NONCE_W-1:0] last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      nonce  <= '0;
      last_q <= '0;
    end else if (load) begin
      nonce  <= nonce_first;
      last_q <= nonce_last;
    end else if (inc) begin
      nonce  <= nonce + NONCE_W'(1);
    end
  end

  // Equality (not ordering) so that ranges with last < first wrap through zero.
  assign is_last = (nonce == last_q);

endmodule

// File: rtl/mining_job_sequencer.sv
// mining_job_sequencer: runs one mining job over the header RAM and hash core.
//   LOAD  : host words (wr_valid/wr_data, wr_ready) are written to RAM[0..HDR_WORDS-1]
//   FEED  : RAM is replayed to the core (feed_valid/feed_data/feed_last) with the
//           current nonce substituted at word NONCE_WORD
//   RUN   : waits for core_done; core_hit ends the job with found=1
//   CHECK : stops with exhausted=1 at nonce_last, otherwise next nonce and FEED again
// Ports: clk, reset (sync, active-high), start, abort, nonce_first, nonce_last,
//   wr_valid, wr_data, wr_ready, ram_we, ram_addr, ram_wdata, ram_rdata (1-cycle
//   latency), feed_valid, feed_data, feed_last, core_done, core_hit, busy, found,
//   exhausted, timeout, nonce_out, state (debug encoding of state_t).
// Build option: define MINING_SEQ_TIMEOUT_EN to end RUN after TIMEOUT_CYC cycles
//   without core_done (DONE with timeout=1); otherwise timeout stays 0.
module mining_job_sequencer
  import mining_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int HDR_WORDS   = HDR_WORDS_DEF,
  parameter int NONCE_WORD  = NONCE_WORD_DEF,
  parameter int TIMEOUT_CYC = 4096
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       nonce_first,
  input  logic [31:0]       nonce_last,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              feed_valid,
  output logic [DATA_W-1:0] feed_data,
  output logic              feed_last,
  input  logic              core_done,
  input  logic              core_hit,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic              timeout,
  output logic [31:0]       nonce_out,
  output logic [2:0]        state
);

`ifdef MINING_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Index is one bit wider than the address so it can reach HDR_WORDS itself
  // (the trailing FEED cycle) even when HDR_WORDS == 2**ADDR_W.
  localparam int              IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] HDR_IDX  = IDX_W'(HDR_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);
  localparam logic [IDX_W-1:0] NW_IDX   = IDX_W'(NONCE_WORD);
  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t             st;
  logic [IDX_W-1:0]   index;
  logic [TMO_W-1:0]   run_cnt;
  logic               vld_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic               nonce_load;
  logic               nonce_inc;
  logic               nonce_is_last;

  assign nonce_load = !abort && start && ((st == ST_IDLE) || (st == ST_DONE));
  assign nonce_inc  = !abort && (st == ST_CHECK) && !nonce_is_last;

  mining_nonce_iter u_nonce (
    .clk         (clk),
    .reset       (reset),
    .load        (nonce_load),
    .inc         (nonce_inc),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .nonce       (nonce_out),
    .is_last     (nonce_is_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_IDLE;
      index     <= '0;
      run_cnt   <= '0;
      vld_p0    <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      timeout   <= 1'b0;
    end else if (abort) begin
      st        <= ST_IDLE;
      index     <= '0;
      vld_p0    <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      case (st)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            st        <= ST_LOAD;
            index     <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (wr_valid) begin
            if (index == LAST_IDX) begin
              st    <= ST_FEED;
              index <= '0;
            end else begin
              index <= index + IDX_ONE;
            end
          end
        end
        ST_FEED: begin
          // HDR_WORDS read cycles, then one trailing cycle for the last read's data.
          if (index == HDR_IDX) begin
            st      <= ST_RUN;
            index   <= '0;
            run_cnt <= '0;
          end else begin
            vld_p0 <= 1'b1;
            index  <= index + IDX_ONE;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            if (core_hit) begin
              st    <= ST_DONE;
              found <= 1'b1;
            end else begin
              st <= ST_CHECK;
            end
          end else if (TMO_EN && (run_cnt == TMO_LAST)) begin
            st      <= ST_DONE;
            timeout <= 1'b1;
          end else begin
            run_cnt <= run_cnt + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          if (nonce_is_last) begin
            st        <= ST_DONE;
            exhausted <= 1'b1;
          end else begin
            st    <= ST_FEED;
            index <= '0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: read index travels with the RAM's one-cycle read latency ----
  always_ff @(posedge clk) begin
    if (st == ST_FEED) idx_p0 <= index;
  end

  assign wr_ready   = (st == ST_LOAD);
  assign ram_we     = wr_valid && wr_ready;
  assign ram_wdata  = wr_data;
  assign ram_addr   = index[ADDR_W-1:0];
  assign feed_valid = vld_p0;
  assign feed_last  = vld_p0 && (idx_p0 == LAST_IDX);
  assign feed_data  = !vld_p0 ? '0 :
                      (idx_p0 == NW_IDX) ? DATA_W'(nonce_out) : ram_rdata;
  assign busy       = is_busy(st);
  assign state      = st;

endmodule

// File: tb/tb_mining_job_sequencer.sv
module tb_mining_job_sequencer;

  localparam int HW = 20;
  localparam int NW = 19;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] nonce_first, nonce_last;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready, ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        feed_valid, feed_last;
  logic [31:0] feed_data;
  logic        core_done, core_hit;
  logic        busy, found, exhausted, timeout;
  logic [31:0] nonce_out;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [31:0] data; logic last; } feed_t;
  feed_t exp_q[$];
  bit    sb_en = 1'b1;

  typedef struct {
    logic [31:0] first;
    logic [31:0] last;
    int          hit_at;
    logic        found;
    logic        exh;
    logic [31:0] nonce;
    int          attempts;
  } vec_t;
  vec_t vecs[5];

  logic [31:0] mem [512];

  always #5 clk = ~clk;

  mining_job_sequencer #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nonce_first(nonce_first), .nonce_last(nonce_last),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .feed_valid(feed_valid), .feed_data(feed_data), .feed_last(feed_last),
    .core_done(core_done), .core_hit(core_hit),
    .busy(busy), .found(found), .exhausted(exhausted), .timeout(timeout),
    .nonce_out(nonce_out), .state(state)
  );

  // Header RAM model: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Feed scoreboard: every word the DUT presents is popped and compared.
  always @(negedge clk) begin
    if (sb_en && feed_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL feed_unexpected got=%h want=none", feed_data);
      end else begin
        feed_t e;
        e = exp_q.pop_front();
        chk("feed_data", feed_data, e.data);
        chk("feed_last", {31'd0, feed_last}, {31'd0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr(input int c, input int i);
    return 32'h1000 + 32'(i) + 32'(c) * 32'h100;
  endfunction

  task automatic push_expected(input int c, input logic [31:0] first, input int attempts);
    for (int a = 0; a < attempts; a++) begin
      for (int i = 0; i < HW; i++) begin
        feed_t e;
        e.data = (i == NW) ? (first + 32'(a)) : hdr(c, i);
        e.last = (i == HW - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input logic [31:0] f, input logic [31:0] l);
    nonce_first = f;
    nonce_last  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", {29'd0, state}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_flags", {30'd0, found, exhausted}, 32'd0);
    chk("start_nonce", nonce_out, f);
  endtask

  // Loads the header for case c; glitch_at >= 0 inserts an idle cycle with a
  // stray core_done/core_hit pulse before that word.
  task automatic load_hdr(input int c, input int glitch_at);
    for (int i = 0; i < HW; i++) begin
      if (i == glitch_at) begin
        wr_valid  = 1'b0;
        core_done = 1'b1;
        core_hit  = 1'b1;
        tick();
        core_done = 1'b0;
        core_hit  = 1'b0;
        chk("glitch_state", {29'd0, state}, 32'd1);
        chk("glitch_addr", {23'd0, ram_addr}, 32'(i));
        chk("glitch_found", {31'd0, found}, 32'd0);
      end
      wr_valid = 1'b1;
      wr_data  = hdr(c, i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_feed_last();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (feed_last) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL feed_last_wait got=none want=feed_last within 80 cycles");
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (state == 3'd5) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL done_wait got=state%0d want=state5", state);
    end
  endtask

  task automatic run_job(input int k);
    vec_t v;
    v = vecs[k];
    do_start(v.first, v.last);
    push_expected(k, v.first, v.attempts);
    load_hdr(k, -1);
    for (int i = 0; i < HW; i++) chk("ram_word", mem[i], hdr(k, i));
    for (int a = 0; a < v.attempts; a++) begin
      wait_feed_last();
      tick();
      tick();
      tick();
      core_done = 1'b1;
      core_hit  = (a == v.hit_at);
      tick();
      core_done = 1'b0;
      core_hit  = 1'b0;
    end
    wait_done();
    chk("job_found", {31'd0, found}, {31'd0, v.found});
    chk("job_exhausted", {31'd0, exhausted}, {31'd0, v.exh});
    chk("job_nonce", nonce_out, v.nonce);
    chk("job_busy", {31'd0, busy}, 32'd0);
    chk("job_timeout", {31'd0, timeout}, 32'd0);
    chk("job_sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'd5, 32'd5, 0, 1'b1, 1'b0, 32'd5, 1};
    vecs[1] = '{32'd0, 32'd2, -1, 1'b0, 1'b1, 32'd2, 3};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, -1, 1'b0, 1'b1, 32'd1, 3};
    vecs[3] = '{32'd100, 32'd200, 2, 1'b1, 1'b0, 32'd102, 3};
    vecs[4] = '{32'd7, 32'd7, -1, 1'b0, 1'b1, 32'd7, 1};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    nonce_first = '0; nonce_last = '0;
    wr_valid = 1'b0; wr_data = '0; core_done = 1'b0; core_hit = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    tick(); tick(); tick();
    reset = 1'b0;

    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_flags", {26'd0, busy, found, exhausted, timeout, feed_valid, wr_ready}, 32'd0);
    chk("rst_addr", {23'd0, ram_addr}, 32'd0);
    chk("rst_nonce", nonce_out, 32'd0);

    for (int k = 0; k < 5; k++) run_job(k);

    // Abort while FEED is at read index 7.
    sb_en = 1'b0;
    do_start(32'd3, 32'd3);
    load_hdr(1, -1);
    for (int i = 0; i < 7; i++) tick();
    chk("abort_pre_addr", {23'd0, ram_addr}, 32'd7);
    chk("abort_pre_valid", {31'd0, feed_valid}, 32'd1);
    chk("abort_pre_data", feed_data, hdr(1, 6));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_flags", {29'd0, busy, found, exhausted}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_valid", {31'd0, feed_valid}, 32'd0);
      tick();
    end
    sb_en = 1'b1;
    run_job(0);

    // start during RUN and core_done during LOAD are both ignored.
    do_start(32'd10, 32'd10);
    push_expected(7, 32'd10, 1);
    load_hdr(7, 5);
    wait_feed_last();
    tick();
    chk("run_entry_state", {29'd0, state}, 32'd3);
    nonce_first = 32'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_state", {29'd0, state}, 32'd3);
    chk("run_start_nonce", nonce_out, 32'd10);
    core_done = 1'b1;
    core_hit  = 1'b1;
    tick();
    core_done = 1'b0;
    core_hit  = 1'b0;
    wait_done();
    chk("ign_found", {31'd0, found}, 32'd1);
    chk("ign_nonce", nonce_out, 32'd10);
    chk("ign_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef MINING_SEQ_TIMEOUT_EN
    do_start(32'd0, 32'd0);
    push_expected(2, 32'd0, 1);
    load_hdr(2, -1);
    wait_feed_last();
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_state_run", {29'd0, state}, 32'd3);
    tick();
    chk("tmo_state_done", {29'd0, state}, 32'd5);
    chk("tmo_flag", {31'd0, timeout}, 32'd1);
    chk("tmo_other", {30'd0, found, exhausted}, 32'd0);
`else
    chk("tmo_tied", {31'd0, timeout}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
